truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_pkg.sv | 24 ++
 rtl/nand_nor_func.sv | 106 ++++++++++
 rtl/truth_table_sweeper.sv | 117 +++++++++++
 3 files changed

// File: rtl/truth_table_pkg.sv
// Shared definitions for the truth-table sweeper: the mode encoding for the
// function network and the sweep controller state type.
package truth_table_pkg;

    localparam int MODE_W = 3;

    // Function select encoding; the value doubles as the index of the result
    // inside the network's function vector.
    localparam logic [MODE_W-1:0] MODE_AND     = 3'd0;
    localparam logic [MODE_W-1:0] MODE_OR      = 3'd1;
    localparam logic [MODE_W-1:0] MODE_NAND    = 3'd2;
    localparam logic [MODE_W-1:0] MODE_NOR     = 3'd3;
    localparam logic [MODE_W-1:0] MODE_XOR     = 3'd4;
    localparam logic [MODE_W-1:0] MODE_XNOR    = 3'd5;
    localparam logic [MODE_W-1:0] MODE_INHIBIT = 3'd6;
    localparam logic [MODE_W-1:0] MODE_IMPLY   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/nand_nor_func.sv
// Combinational function network: evaluates the selected logic function of
// vec under mode using nothing but 2-input NAND and NOR gates. Every derived
// gate (inverter, AND, OR, XOR, decoder, mux) is composed from nand2/nor2.
module nand_nor_func
    import truth_table_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0]   vec,
    input  logic [MODE_W-1:0] mode,
    output logic              s
);

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    function automatic logic nor2(input logic x, input logic y);
        return ~(x | y);
    endfunction

    function automatic logic inv(input logic x);
        return nand2(x, x);
    endfunction

    function automatic logic and2(input logic x, input logic y);
        return inv(nand2(x, y));
    endfunction

    function automatic logic or2(input logic x, input logic y);
        return inv(nor2(x, y));
    endfunction

    function automatic logic xor2(input logic x, input logic y);
        logic t;
        t = nand2(x, y);
        return nand2(nand2(x, t), nand2(y, t));
    endfunction

    // One-hot decode of a 3-bit select against a fixed code.
    function automatic logic dec3(input logic [2:0] m, input logic [2:0] code);
        logic l0, l1, l2;
        l0 = code[0] ? m[0] : inv(m[0]);
        l1 = code[1] ? m[1] : inv(m[1]);
        l2 = code[2] ? m[2] : inv(m[2]);
        return and2(and2(l0, l1), l2);
    endfunction

    logic              and_all;
    logic              or_all;
    logic              xor_all;
    logic              and_rest;
    logic              a_n;
    logic              inhibit;
    logic              imply;
    logic [7:0]        f;
    logic              sum_n;

    // Reduce the inputs, build all eight candidate functions, then select one.
    always_comb begin
        // NOTE: blocking assignments in combinational logic, so each stage of a
        // reduction chain sees the value produced by the previous stage.
        and_all = vec[0];
        or_all  = vec[0];
        xor_all = vec[0];
        for (int i = 1; i < N_IN; i++) begin
            and_all = and2(and_all, vec[i]);
            or_all  = or2(or_all, vec[i]);
            xor_all = xor2(xor_all, vec[i]);
        end

        // AND of every input except the MSB "a".
        and_rest = vec[0];
        for (int i = 1; i < N_IN - 1; i++) begin
            and_rest = and2(and_rest, vec[i]);
        end

        a_n = inv(vec[N_IN-1]);
        if (N_IN == 1) begin
            // With a single input there is no "rest": both collapse to ~a.
            inhibit = a_n;
            imply   = a_n;
        end else begin
            inhibit = and2(a_n, and_rest);
            imply   = or2(a_n, and_rest);
        end

        f               = '0;
        f[MODE_AND]     = and_all;
        f[MODE_OR]      = or_all;
        f[MODE_NAND]    = inv(and_all);
        f[MODE_NOR]     = inv(or_all);
        f[MODE_XOR]     = xor_all;
        f[MODE_XNOR]    = inv(xor_all);
        f[MODE_INHIBIT] = inhibit;
        f[MODE_IMPLY]   = imply;

        // Sum-of-products mux as NAND-NAND: s = ~&(~(sel_k & f_k)).
        sum_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            sum_n = and2(sum_n, nand2(dec3(mode, 3'(k)), f[k]));
        end
        s = inv(sum_n);
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: on an accepted start it latches mode, walks vec through
// every input combination, captures the function output for each vector into
// table_out, then pulses done for one cycle.
// Optional feature macro: TT_SWEEP_CHECK_EN adds the expected input and the
// mismatch output comparing the captured table against it.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter  int N_IN = 2,
    localparam int TT_W = 2 ** N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
`ifdef TT_SWEEP_CHECK_EN
    input  logic [TT_W-1:0]   expected,
    output logic              mismatch,
`endif
    output logic [N_IN-1:0]   vec,
    output logic              s,
    output logic [TT_W-1:0]   table_out,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   cnt_q, cnt_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic [TT_W-1:0]   table_q, table_d;
`ifdef TT_SWEEP_CHECK_EN
    logic [TT_W-1:0]   expected_q, expected_d;
`endif

    nand_nor_func #(
        .N_IN (N_IN)
    ) u_func (
        .vec  (cnt_q),
        .mode (mode_q),
        .s    (s)
    );

    // Sweep controller: next state, counter, mode latch and table capture.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can leave one
        // unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        table_d = table_q;
`ifdef TT_SWEEP_CHECK_EN
        expected_d = expected_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                    mode_d  = mode;
                    table_d = '0;
`ifdef TT_SWEEP_CHECK_EN
                    expected_d = expected;
`endif
                end
            end
            ST_SWEEP: begin
                table_d[cnt_q] = s;
                // Counter is exactly N_IN bits, so the last vector wraps to 0.
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all flops so every register
            // samples pre-edge values.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_AND;
            // NOTE: the capture table is a flop bank, not a RAM, so it is reset
            // with the rest of the state.
            table_q <= '0;
`ifdef TT_SWEEP_CHECK_EN
            expected_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            table_q <= table_d;
`ifdef TT_SWEEP_CHECK_EN
            expected_q <= expected_d;
`endif
        end
    end

    assign vec       = cnt_q;
    assign table_out = table_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

`ifdef TT_SWEEP_CHECK_EN
    assign mismatch  = done && (table_q != expected_q);
`endif

endmodule
